sym_err_counter: RTL



---
 rtl/sym_err_counter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sym_err_counter.sv
// sym_err_counter: symbol and bit error counter for an LFSR loopback link.
// The reference symbol stream is delayed by DELAY enabled samples and compared
// with the slicer decisions. Errors are accumulated over one LFSR period, which
// is delimited by cycle_start. Totals are latched once per period.
//
// Optional feature macro: SYM_ERR_BIT_COUNT_EN
//   defined     - popcount datapath and bit error accumulator are built.
//   not defined - no bit error logic; bit_err_count is tied to 0.
//
// Handshake: there is no back-pressure. result_valid is a one-clk pulse that
// marks the cycle in which sym_total/sym_err_count/bit_err_count/error_free
// take new values. Those outputs then hold until the next pulse.
module sym_err_counter #(
    parameter int DELAY = 8,
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [3:0]       ref_sym,
    input  logic [3:0]       rx_sym,
    input  logic             cycle_start,
    output logic [CNT_W-1:0] sym_total,
    output logic [CNT_W-1:0] sym_err_count,
    output logic [CNT_W+1:0] bit_err_count,
    output logic             result_valid,
    output logic             error_free
);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;

    localparam logic [5:0] FILL_LAST = 6'(DELAY - 1);

    // Current FSM state; kept as a plainly named signal so checkers can bind to it.
    logic [1:0]       state;
    logic [5:0]       fill_cnt;
    logic [3:0]       dly [DELAY];
    logic [3:0]       ref_d;
    logic             sym_err;
    logic             load_win;
    logic             latch_win;
    logic             accum;
    logic [CNT_W-1:0] acc_total;
    logic [CNT_W-1:0] acc_sym;
    logic [CNT_W-1:0] acc_total_nxt;
    logic [CNT_W-1:0] acc_sym_nxt;

    assign ref_d   = dly[DELAY-1];
    assign sym_err = (ref_d != rx_sym);

    // A window opens on the first qualified cycle_start after FILL and on every
    // later one; only those seen in COUNT close a window and publish results.
    assign load_win  = clk_en && cycle_start && ((state == ST_SYNC) || (state == ST_COUNT));
    assign latch_win = clk_en && cycle_start && (state == ST_COUNT);
    assign accum     = clk_en && !cycle_start && (state == ST_COUNT);

    // Reference delay line: advances once per enabled sample, zeroed on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) begin
                dly[i] <= 4'd0;
            end
        end else if (clk_en) begin
            dly[0] <= ref_sym;
            for (int i = 1; i < DELAY; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    // Control FSM: fill the delay line, wait for a period boundary, then count forever.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FILL;
            fill_cnt <= 6'd0;
        end else if (clk_en) begin
            case (state)
                ST_FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state <= ST_SYNC;
                    end else begin
                        fill_cnt <= fill_cnt + 6'd1;
                    end
                end
                ST_SYNC: begin
                    if (cycle_start) begin
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    state <= ST_COUNT;
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

    // Saturating increments for the symbol counters.
    always_comb begin
        acc_total_nxt = acc_total;
        acc_sym_nxt   = acc_sym;
        if (acc_total != '1) begin
            acc_total_nxt = acc_total + CNT_W'(1);
        end
        if (sym_err && (acc_sym != '1)) begin
            acc_sym_nxt = acc_sym + CNT_W'(1);
        end
    end

    // Symbol accumulators: the cycle_start sample is the first sample of a new window.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_total <= '0;
            acc_sym   <= '0;
        end else if (load_win) begin
            acc_total <= CNT_W'(1);
            acc_sym   <= CNT_W'(sym_err);
        end else if (accum) begin
            acc_total <= acc_total_nxt;
            acc_sym   <= acc_sym_nxt;
        end
    end

    // Result registers: copy the closing window and pulse result_valid for one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_total     <= '0;
            sym_err_count <= '0;
            result_valid  <= 1'b0;
            error_free    <= 1'b0;
        end else begin
            result_valid <= latch_win;
            if (latch_win) begin
                sym_total     <= acc_total;
                sym_err_count <= acc_sym;
                error_free    <= (acc_sym == '0) && (acc_total != '0);
            end
        end
    end

`ifdef SYM_ERR_BIT_COUNT_EN
    logic [3:0]       diff;
    logic [2:0]       bit_err;
    logic [CNT_W+1:0] acc_bit;
    logic [CNT_W+2:0] acc_bit_sum;
    logic [CNT_W+1:0] acc_bit_nxt;

    assign diff    = ref_d ^ rx_sym;
    assign bit_err = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);

    // Saturating add of this sample's bit errors.
    always_comb begin
        acc_bit_sum = {1'b0, acc_bit} + (CNT_W+3)'(bit_err);
        acc_bit_nxt = acc_bit_sum[CNT_W+1:0];
        if (acc_bit_sum[CNT_W+2]) begin
            acc_bit_nxt = '1;
        end
    end

    // Bit error accumulator and its latched copy, aligned with the symbol path.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_bit       <= '0;
            bit_err_count <= '0;
        end else begin
            if (load_win) begin
                acc_bit <= (CNT_W+2)'(bit_err);
            end else if (accum) begin
                acc_bit <= acc_bit_nxt;
            end
            if (latch_win) begin
                bit_err_count <= acc_bit;
            end
        end
    end
`else
    assign bit_err_count = '0;
`endif

endmodule
